// File: rtl/wide_add_sequencer.sv
// Sequences a W-bit add through an external 8-bit adder, one byte per cycle, LSB first.
// Optional subtract mode (in_sub port) is enabled by defining WIDE_ADD_SUB_EN.
module wide_add_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                  in_sub,
`endif
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [7:0]       a_byte, b_byte;
    logic             sub_in;

`ifdef WIDE_ADD_SUB_EN
    assign sub_in = in_sub;
`else
    assign sub_in = 1'b0;
`endif

    // Byte select toward the external adder; kept apart from the FSM so add_sum feedback is acyclic.
    always_comb begin
        a_byte  = 8'd0;
        b_byte  = 8'd0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
            end
        end
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_byte;
            add_b   = sub_q ? ~b_byte : b_byte;
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sub_d     = sub_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = sub_in;
                    // Subtract is A + ~B + 1, so the seed carry is forced high.
                    carry_d = sub_in ? 1'b1 : in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[8*i +: 8] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_sum  = sum_q;
    assign out_cout = carry_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (NBYTES=4) with a behavioural 8-bit adder.
// Subtract cases run only when WIDE_ADD_SUB_EN is defined.
module tb_wide_add_sequencer;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;
    int   accept_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

    wide_add_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef WIDE_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        model.sum  = r[W-1:0];
        model.cout = r[W];
    endfunction

    // Compare every accepted result against the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_sum", 64'(out_sum), 64'(e.sum));
                check("out_cout", 64'(out_cout), 64'(e.cout));
            end
        end
    end

    // Drive an operand pair (called just after a rising edge) and return just after its accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        sb.push_back(model(a, b, cin, sub));
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        accept_cyc = cycle;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
        in_sub   = 1'($urandom);
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) check("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    // Check add_cin per RUN cycle and exact output latency; entered just after accept.
    task automatic run_trace(input logic [3:0] cin_seq);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("add_cin_b%0d", k), 64'(add_cin), 64'(cin_seq[k]));
            check($sformatf("run_no_valid_b%0d", k), 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check("latency_valid", 64'(out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e1;
        int   t1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        @(posedge clk); #1;

        // Carry out of byte 0 only.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_trace(4'b0010);
        drain();

        // Carry ripples through every byte.
        @(posedge clk); #1;
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_trace(4'b1111);
        drain();

        // Backpressure with a second pair waiting.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'hA5A5_0F0F, 32'h1234_F1F1, 1'b0, 1'b0);
        e1 = model(32'hA5A5_0F0F, 32'h1234_F1F1, 1'b0, 1'b0);
        wait_valid();
        in_valid = 1'b1;
        in_a     = 32'h0000_0001;
        in_b     = 32'h7FFF_FFFF;
        in_cin   = 1'b0;
        in_sub   = 1'b0;
        sb.push_back(model(32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0));
        for (int s = 0; s < 3; s++) begin
            if (s != 0) @(negedge clk);
            check("bp_valid_held", 64'(out_valid), 64'd1);
            check("bp_sum_held", 64'(out_sum), 64'(e1.sum));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset two cycles into RUN discards the transaction.
        @(posedge clk); #1;
        send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_add_a", 64'(add_a), 64'd0);
        check("mid_rst_add_b", 64'(add_b), 64'd0);
        check("mid_rst_add_cin", 64'(add_cin), 64'd0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("mid_rst_no_valid", 64'(out_valid), 64'd0);
        end

        // Back-to-back transactions, accepts NBYTES+2 apart.
        @(posedge clk); #1;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        t1 = accept_cyc;
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        check("b2b_spacing", 64'(accept_cyc - t1), 64'd6);
        drain();
        check("b2b_model_1", 64'(model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0)), {31'd0, 32'h2345_6789, 1'b0});

`ifdef WIDE_ADD_SUB_EN
        @(posedge clk); #1;
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        drain();
        @(posedge clk); #1;
        send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        drain();
`endif

        // A few random transactions under fixed readiness.
        for (int r = 0; r < 6; r++) begin
            @(posedge clk); #1;
            send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Upstream/downstream control stage wrapped around the team's 8-bit carry-lookahead adder.
- Accepts one wide operand pair per transaction and feeds the adder one byte per cycle, LSB first.
- Captures each byte of sum and chains the adder's carry-out into the next byte's carry-in.
- Returns the full-width sum and final carry through a valid/ready output handshake.

Parameters:
NBYTES, 4, operand width in bytes (>=1); data width W = 8*NBYTES

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in for byte 0
add_a  output  8  byte of A to external 8-bit adder
add_b  output  8  byte of B to external 8-bit adder
add_cin  output  1  carry to external adder
add_sum  input  8  adder sum, combinational from add_a/add_b/add_cin
add_cout  input  1  adder carry-out
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  W  full sum
out_cout  output  1  final carry-out

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset: state IDLE, byte index 0, carry reg 0, out_sum 0, out_cout 0, out_valid 0, in_ready 1.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch in_a, in_b; carry<=in_cin; idx<=0; go to RUN.
  - RUN: in_ready=0. add_a=A[8*idx+:8], add_b=B[8*idx+:8], add_cin=carry. Each edge: sum[8*idx+:8]<=add_sum; carry<=add_cout; idx<=idx+1. When idx==NBYTES-1, go to DONE.
  - DONE: out_valid=1, out_sum=sum reg, out_cout=carry. On out_ready, go to IDLE.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- Latency: out_valid rises exactly NBYTES cycles after the accept edge.
- Throughput: one transaction per NBYTES+2 cycles minimum. No accept in DONE, even on the same cycle as out_ready.
- While out_valid && !out_ready, out_sum and out_cout are held stable. Once out_valid is high it stays high until accepted.
- in_a, in_b and in_cin changes after the accept edge have no effect on the transaction in flight.
- NBYTES=1: RUN lasts one cycle.
- Index counter width: $clog2(NBYTES), minimum 1 bit. It never wraps past NBYTES-1.
- Reset mid-RUN or mid-DONE: transaction is discarded, no out_valid is produced, and in_ready=1 on the cycle after reset is released.
- The external adder is purely combinational; add_sum and add_cout are sampled on the same edge as the add_* drive.

Optional Feature:
- Macro: WIDE_ADD_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), latched at accept.
  - When in_sub=1: add_b = ~B byte, initial carry=1, in_cin ignored, result = A-B mod 2^W. out_cout=1 means no borrow (A>=B unsigned).
  - When in_sub=0: behaviour identical to the undefined case.
- Undefined: no in_sub port; addition only.

Test Plan:
- NBYTES=4: A=0x000000FF, B=0x00000001, cin=0 -> out_sum=0x00000100, out_cout=0. out_valid high exactly 4 cycles after accept. Per-cycle check: add_cin sequence 0,1,0,0.
- A=0xFFFFFFFF, B=0x00000000, cin=1 -> out_sum=0x00000000, out_cout=1. Carry ripples across all 4 byte steps.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_sum and out_valid stable, in_ready=0 while in_valid held high. Release -> in_ready=1 the next cycle and the second operand pair is accepted.
- Reset mid-RUN: assert rst for 1 cycle 2 cycles after accept -> out_valid never rises; in_ready=1 on the cycle after rst deasserts; add_* outputs are 0.
- Back-to-back: two transactions (0x12345678+0x11111111=0x23456789 cout 0; 0x80000000+0x80000000=0x00000000 cout 1) with out_ready=1 -> both results correct and in order, accepts spaced 6 cycles apart.
- WIDE_ADD_SUB_EN defined: in_sub=1, A=0x00000005, B=0x00000007 -> out_sum=0xFFFFFFFE, out_cout=0. Then A=7, B=5 -> out_sum=0x00000002, out_cout=1.
